expr_ctrl: RTL and testbench
============================

EXPR_CTRL -- requirements
Module: expr_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 clr_n  input  1  reset; asynchronous, active-low.
REQ-003 req0, req1  input  1 each  requester holds high to request or keep an expression session.
REQ-004 byte0, byte1  input  8 each  ASCII character stream per requester.
REQ-005 vld0, vld1  input  1 each  byte valid per requester.
REQ-006 rdy0, rdy1  output  1 each  controller accepts the byte; a transfer occurs when vld and rdy are both high at a clk edge.
REQ-007 gnt  output  2  one-hot session grant; bit0 is requester 0, bit1 is requester 1.
REQ-008 done  output  1  one-cycle pulse when a session terminates with '='.
REQ-009 ok  output  1  expression valid; qualified by done, held until the next done.
REQ-010 result  output  8  expression value mod 256; qualified by done, held until the next done.
REQ-011 owner  output  1  index of the requester whose session produced done; held until the next done.

Function
REQ-012 States: IDLE, EXP_NUM (a digit is expected), EXP_OP (an operator or '=' is expected), ERR, DONE.
REQ-013 IDLE, no req: stay in IDLE with gnt=00.
REQ-014 IDLE, one req high: next cycle, gnt grants that requester and the state becomes EXP_NUM.
REQ-015 IDLE, both req high: grant goes round-robin to the requester not granted last. After reset, requester 0 wins.
REQ-016 rdyN = gnt[N] and state in {EXP_NUM, EXP_OP, ERR}. rdy of the ungranted requester is 0, and its bytes are ignored.
REQ-017 Only transferred bytes of the granted requester advance the FSM. One byte is consumed per cycle at most.
REQ-018 EXP_NUM transitions:
  - '0'-'9' goes to EXP_OP.
  - '=' goes to DONE with ok=0.
  - Any other byte goes to ERR.
REQ-019 EXP_OP transitions:
  - '+' or '*' goes to EXP_NUM.
  - '=' goes to DONE with ok=1.
  - Any other byte goes to ERR.
  - Consequence: a multi-digit number goes to ERR.
REQ-020 ERR: consume bytes until '=', then go to DONE with ok=0.
REQ-021 Evaluation uses 8-bit registers sum (reset 0) and prod (reset 1), cleared at grant. '*' binds tighter than '+'.
  - Digit d: prod = prod*d mod 256.
  - '+': sum = sum+prod, then prod = 1.
  - '*': no change.
REQ-022 Transfer of '=': registers result=(sum+prod) mod 256 when ok=1, else result=0. ok and owner are registered at the same edge, and done=1 on the next cycle.
REQ-023 DONE lasts one cycle with gnt held and rdy=0, then the state returns to IDLE with gnt=00. Arbitration resumes in IDLE, so a re-grant occurs at the earliest 2 cycles after done.
REQ-024 The granted requester dropping req in EXP_NUM, EXP_OP or ERR aborts the session: next cycle goes to IDLE with gnt=00, no done, and result, ok and owner unchanged.
REQ-025 Once a requester is granted, the other requester's req is ignored until the state returns to IDLE.

Reset
REQ-026 clr_n low asynchronously forces:
  - state IDLE, gnt=00, rdy0=rdy1=0, done=0, ok=0, result=0, owner=0;
  - sum=0, prod=1, round-robin pointer set to favour requester 0.
REQ-027 Reset mid-session discards the session and produces no done. Operation restarts on the first clk edge after clr_n rises.

Configuration
REQ-028 Macro EXPR_CTRL_EVAL_EN.
  - Defined: REQ-021 arithmetic is present.
  - Undefined: sum and prod are omitted, result is constant 0, and grammar checking, ok, done, owner and arbitration are unchanged.

Verification
REQ-029 Requester 0 streams "2+3*4=" with vld always high. Required: gnt=01, done one cycle after the '=' transfer, ok=1, result=14, owner=0.
REQ-030 Requester 1 streams "9*9*9=". Required: ok=1, result=217 (729 mod 256), owner=1.
REQ-031 Stream "2++3=" then "12=".
  - Each required response: ERR entered, done with ok=0 and result=0.
  - "=" alone: done with ok=0.
REQ-032 req0 and req1 rise in the same cycle after reset, each sending "1=".
  - Required: gnt=01 first, then gnt=10.
  - Required: two done pulses with owner 0 then 1, each result=1.
REQ-033 Drop req0 after "5+". Separately, pull clr_n low after "5*".
  - Each required response: no done, gnt=00 next cycle or immediately, prior result held for the abort, reset values for the reset.
REQ-034 Build with EXPR_CTRL_EVAL_EN undefined and rerun REQ-029. Required: done, ok=1, result=0.

Source files
------------

// File: rtl/expr_ctrl_if.sv
// expr_ctrl_if: requester byte streams, handshake and session results for expr_ctrl
//   master (requester side) drives req/byte/vld; slave (expr_ctrl) drives rdy/gnt/done/ok/result/owner
interface expr_ctrl_if;
  logic req0, req1, vld0, vld1, rdy0, rdy1, done, ok, owner;
  logic [7:0] byte0, byte1, result;
  logic [1:0] gnt;
  modport master (
    output req0, req1, byte0, byte1, vld0, vld1,
    input  rdy0, rdy1, gnt, done, ok, result, owner
  );
  modport slave (
    input  req0, req1, byte0, byte1, vld0, vld1,
    output rdy0, rdy1, gnt, done, ok, result, owner
  );
endinterface

// File: rtl/expr_ctrl.sv
// expr_ctrl: two-requester round-robin session arbiter with ASCII expression grammar check/evaluator
//   clk   : rising-edge clock
//   clr_n : asynchronous active-low reset
//   bus   : expr_ctrl_if.slave (req/byte/vld in, rdy/gnt/done/ok/result/owner out)
//   build macro EXPR_CTRL_EVAL_EN enables sum/prod arithmetic; otherwise result is constant 0
module expr_ctrl (
  input logic        clk,
  input logic        clr_n,
  expr_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, EXP_NUM, EXP_OP, ERR, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0] r_gnt, w_gnt;
  logic r_last, r_ok, r_owner;
  logic w_req, w_vld, w_act, w_xfer, w_digit, w_op, w_eq, w_grant, w_fin;
  logic [7:0] w_byte;
  assign w_req = r_gnt[1] ? bus.req1 : bus.req0;
  assign w_vld = r_gnt[1] ? bus.vld1 : bus.vld0;
  assign w_byte = r_gnt[1] ? bus.byte1 : bus.byte0;
  assign w_act = r_state == EXP_NUM || r_state == EXP_OP || r_state == ERR;
  // a dropped req aborts the session, so a byte offered in that cycle is discarded
  assign w_xfer = w_act && w_req && w_vld;
  assign w_digit = w_byte >= 8'h30 && w_byte <= 8'h39;
  assign w_op = w_byte == 8'h2B || w_byte == 8'h2A;
  assign w_eq = w_byte == 8'h3D;
  assign w_grant = r_state == IDLE && (bus.req0 || bus.req1);
  assign w_fin = w_xfer && w_eq;
  assign bus.rdy0 = r_gnt[0] && w_act;
  assign bus.rdy1 = r_gnt[1] && w_act;
  assign bus.gnt = r_gnt;
  assign bus.done = r_state == DONE;
  assign bus.ok = r_ok;
  assign bus.owner = r_owner;
  always_comb begin
    w_next = r_state;
    w_gnt = r_gnt;
    case (r_state)
      IDLE: if (w_grant) begin
        w_next = EXP_NUM;
        // r_last holds the index granted last; on contention the other one wins
        w_gnt = (bus.req0 && bus.req1) ? (r_last ? 2'b01 : 2'b10) : {bus.req1, bus.req0};
      end
      EXP_NUM, EXP_OP, ERR: if (!w_req) begin
        w_next = IDLE;
        w_gnt = 2'b00;
      end else if (w_xfer)
        w_next = w_eq ? DONE :
                 (r_state == EXP_NUM && w_digit) ? EXP_OP :
                 (r_state == EXP_OP && w_op) ? EXP_NUM : ERR;
      default: begin
        w_next = IDLE;
        w_gnt = 2'b00;
      end
    endcase
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_state <= IDLE;
      r_gnt <= 2'b00;
      r_last <= 1'b1;
      r_ok <= 1'b0;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gnt <= w_gnt;
      if (w_grant) r_last <= w_gnt[1];
      if (w_fin) begin
        r_ok <= r_state == EXP_OP;
        r_owner <= r_gnt[1];
      end
    end
`ifdef EXPR_CTRL_EVAL_EN
  logic [7:0] r_sum, r_prod, r_result;
  // prod accumulates the current product term, sum the completed terms
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_sum <= 8'd0;
      r_prod <= 8'd1;
      r_result <= 8'd0;
    end else if (w_grant) begin
      r_sum <= 8'd0;
      r_prod <= 8'd1;
    end else if (w_fin)
      r_result <= r_state == EXP_OP ? r_sum + r_prod : 8'd0;
    else if (w_xfer && r_state == EXP_NUM && w_digit)
      r_prod <= r_prod * {4'd0, w_byte[3:0]};
    else if (w_xfer && r_state == EXP_OP && w_byte == 8'h2B) begin
      r_sum <= r_sum + r_prod;
      r_prod <= 8'd1;
    end
  assign bus.result = r_result;
`else
  assign bus.result = 8'd0;
`endif
endmodule

// File: tb/tb_expr_ctrl.sv
// tb_expr_ctrl: table-driven sessions plus arbitration, abort and reset sequences for expr_ctrl
module tb_expr_ctrl;
`ifdef EXPR_CTRL_EVAL_EN
  localparam logic EVAL = 1'b1;
`else
  localparam logic EVAL = 1'b0;
`endif
  logic clk = 1'b0;
  logic clr_n = 1'b1;
  expr_ctrl_if bus();
  expr_ctrl dut (.clk(clk), .clr_n(clr_n), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  typedef struct {
    int          idx;
    logic [63:0] s;
    int          len;
    logic        ok;
    logic [7:0]  res;
  } vec_t;
  vec_t v[9];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int idx, input logic val);
    if (idx == 0) bus.req0 = val; else bus.req1 = val;
  endtask
  task automatic drive(input int idx, input logic vld, input logic [7:0] b);
    if (idx == 0) begin bus.vld0 = vld; bus.byte0 = b; end
    else begin bus.vld1 = vld; bus.byte1 = b; end
  endtask
  function automatic logic rdy_of(input int idx);
    return idx == 0 ? bus.rdy0 : bus.rdy1;
  endfunction
  task automatic grant(input int idx);
    int n = 0;
    set_req(idx, 1'b1);
    do begin cyc(); n++; end while (!bus.gnt[idx] && n < 10);
    chk("grant", bus.gnt, idx == 0 ? 2'b01 : 2'b10);
  endtask
  task automatic send(input int idx, input logic [7:0] b);
    int n = 0;
    drive(idx, 1'b1, b);
    while (!rdy_of(idx) && n < 20) begin cyc(); n++; end
    chk("rdy", rdy_of(idx), 1);
    cyc();
    drive(idx, 1'b0, 8'h00);
  endtask
  task automatic send_str(input int idx, input logic [63:0] s, input int len);
    for (int i = 0; i < len; i++) send(idx, s[8*(len-1-i) +: 8]);
  endtask
  task automatic chk_done(input string n, input int idx, input logic ok, input logic [7:0] res);
    chk({n, " done"}, bus.done, 1);
    chk({n, " ok"}, bus.ok, ok);
    chk({n, " result"}, bus.result, EVAL ? res : 8'd0);
    chk({n, " owner"}, bus.owner, idx);
    chk({n, " gnt held"}, bus.gnt, idx == 0 ? 2'b01 : 2'b10);
    chk({n, " rdy in done"}, {bus.rdy1, bus.rdy0}, 0);
  endtask
  initial begin
    v[0] = '{0, "2+3*4=", 6, 1'b1, 8'd14};
    v[1] = '{1, "9*9*9=", 6, 1'b1, 8'd217};
    v[2] = '{0, "2++3=", 5, 1'b0, 8'd0};
    v[3] = '{1, "12=", 3, 1'b0, 8'd0};
    v[4] = '{0, "=", 1, 1'b0, 8'd0};
    v[5] = '{1, "3*0+7=", 6, 1'b1, 8'd7};
    v[6] = '{0, "x5=", 3, 1'b0, 8'd0};
    v[7] = '{1, "5+=", 3, 1'b0, 8'd0};
    v[8] = '{0, "8*8*8+1=", 8, 1'b1, 8'd1};
    bus.req0 = 0; bus.req1 = 0; bus.vld0 = 0; bus.vld1 = 0; bus.byte0 = 0; bus.byte1 = 0;
    #3 clr_n = 0;
    #1;
    chk("reset gnt", bus.gnt, 0);
    chk("reset rdy", {bus.rdy1, bus.rdy0}, 0);
    chk("reset done", bus.done, 0);
    chk("reset ok", bus.ok, 0);
    chk("reset result", bus.result, 0);
    chk("reset owner", bus.owner, 0);
    cyc(); cyc();
    clr_n = 1;
    cyc();
    chk("idle no req", bus.gnt, 0);
    // simultaneous requests: requester 0 first, then round-robin to 1
    bus.req0 = 1; bus.req1 = 1;
    cyc();
    chk("rr first gnt", bus.gnt, 2'b01);
    chk("rr ungranted rdy1", bus.rdy1, 0);
    drive(1, 1'b1, 8'h3D);
    send_str(0, "1=", 2);
    chk_done("rr0", 0, 1'b1, 8'd1);
    bus.req0 = 0;
    cyc();
    chk("rr done pulse", bus.done, 0);
    chk("rr gnt idle", bus.gnt, 0);
    drive(1, 1'b0, 8'h00);
    cyc();
    chk("rr second gnt", bus.gnt, 2'b10);
    send_str(1, "1=", 2);
    chk_done("rr1", 1, 1'b1, 8'd1);
    bus.req1 = 0;
    cyc();
    // abort after "5+": no done, results held
    grant(0);
    send_str(0, "5+", 2);
    bus.req0 = 0;
    chk("abort no done", bus.done, 0);
    cyc();
    chk("abort gnt", bus.gnt, 0);
    chk("abort done", bus.done, 0);
    chk("abort result held", bus.result, EVAL ? 8'd1 : 8'd0);
    chk("abort ok held", bus.ok, 1);
    chk("abort owner held", bus.owner, 1);
    // reset after "5*": immediate return to reset values
    grant(0);
    send_str(0, "5*", 2);
    #2 clr_n = 0;
    #1;
    chk("mid reset gnt", bus.gnt, 0);
    chk("mid reset rdy0", bus.rdy0, 0);
    chk("mid reset ok", bus.ok, 0);
    chk("mid reset owner", bus.owner, 0);
    chk("mid reset result", bus.result, 0);
    chk("mid reset done", bus.done, 0);
    bus.req0 = 0;
    cyc(); cyc();
    clr_n = 1;
    cyc();
    chk("post reset gnt", bus.gnt, 0);
    for (int i = 0; i < 9; i++) begin
      grant(v[i].idx);
      send_str(v[i].idx, v[i].s, v[i].len);
      chk_done($sformatf("vec%0d", i), v[i].idx, v[i].ok, v[i].res);
      set_req(v[i].idx, 1'b0);
      cyc();
      chk($sformatf("vec%0d done pulse", i), bus.done, 0);
      chk($sformatf("vec%0d gnt idle", i), bus.gnt, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
